// File: rtl/fetch_sequencer.sv
// Purpose : control/fetch stage; owns the PC, reads instruction and operand
//           words over REQ/ACK, decodes them into IR/AR/DR load strobes and
//           hands non-local instructions to execute over VALID/DONE.
// Latency : cycles per instruction with zero-wait ACK/DONE: NOP/JMP/JZ 2,
//           STA 3, LDA/ADD 5.
// Backpressure: stalls in FETCH/OPER until MEM_ACK and in EXEC until
//           EXEC_DONE; ACK and DONE are ignored in every other state.
//
// Ports:
//   CLK, RSTN           clock, asynchronous active-low reset
//   MEM_REQ/ADDR/ACK/RDATA   memory read handshake (request held until ACK)
//   LD_IR/IR_DATA       opcode strobe + data to the instruction register
//   LD_AR/AR_DATA       address strobe + data to the address register
//   LD_DR/DR_DATA       operand strobe + data to the data register
//   EXEC_VALID/EXEC_DONE execute handshake
//   ZERO                accumulator-zero flag consumed by JZ
//   PC, HALTED          program counter and halt status
module fetch_sequencer #(
  parameter int                 ADDR_W   = 6,
  parameter int                 DATA_W   = 9,
  parameter int                 OP_W     = 3,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              LD_IR,
  output logic [OP_W-1:0]   IR_DATA,
  output logic              LD_AR,
  output logic [ADDR_W-1:0] AR_DATA,
  output logic              LD_DR,
  output logic [DATA_W-1:0] DR_DATA,
  output logic              EXEC_VALID,
  input  logic              EXEC_DONE,
  input  logic              ZERO,
  output logic [ADDR_W-1:0] PC,
  output logic              HALTED
);

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPER, S_LOADDR, S_EXEC, S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [OP_W-1:0]     ir_q, ir_d;
  logic [ADDR_W-1:0]   ar_q, ar_d;
  logic [DATA_W-1:0]   dr_q, dr_d;

  // State and datapath registers. Reset is asynchronous so an in-flight
  // memory or execute handshake is dropped without waiting for a clock.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ar_q    <= '0;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
      dr_q    <= dr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (MEM_ACK) state_d = S_DECODE;
      S_DECODE: begin
        case (ir_q)
          OP_LDA, OP_ADD: state_d = S_OPER;
          OP_STA:         state_d = S_EXEC;
          OP_HLT:         state_d = S_HALT;
          default:        state_d = S_FETCH;  // NOP, JMP, JZ, reserved
        endcase
      end
      S_OPER:   if (MEM_ACK) state_d = S_LOADDR;
      S_LOADDR: state_d = S_EXEC;
      S_EXEC:   if (EXEC_DONE) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-state. The fetched word lands directly in the IR/AR
  // holding registers on the ACK edge, so both are already registered and
  // stable for the whole DECODE cycle in which their strobes fire.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    ar_d = ar_q;
    dr_d = dr_q;
    if (state_q == S_FETCH && MEM_ACK) begin
      ir_d = MEM_RDATA[DATA_W-1:ADDR_W];
      ar_d = MEM_RDATA[ADDR_W-1:0];
      pc_d = pc_q + ADDR_W'(1);  // natural wrap at the top of memory
    end
    // Jumps are resolved here rather than in execute; the PC already points
    // past the jump, so an untaken JZ simply falls through.
    if (state_q == S_DECODE) begin
      if (ir_q == OP_JMP || (ir_q == OP_JZ && ZERO)) begin
        pc_d = ar_q;
      end
    end
    if (state_q == S_OPER && MEM_ACK) begin
      dr_d = MEM_RDATA;
    end
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    MEM_REQ    = 1'b0;
    MEM_ADDR   = pc_q;
    LD_IR      = 1'b0;
    LD_AR      = 1'b0;
    LD_DR      = 1'b0;
    EXEC_VALID = 1'b0;
    HALTED     = 1'b0;
    case (state_q)
      S_FETCH:  MEM_REQ = 1'b1;
      S_DECODE: begin
        LD_IR = 1'b1;
        LD_AR = 1'b1;
      end
      S_OPER: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = ar_q;
      end
      S_LOADDR: LD_DR      = 1'b1;
      S_EXEC:   EXEC_VALID = 1'b1;
      S_HALT:   HALTED     = 1'b1;
      default:  ;
    endcase
  end

  assign IR_DATA = ir_q;
  assign AR_DATA = ar_q;
  assign DR_DATA = dr_q;
  assign PC      = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose : self-checking bench for fetch_sequencer; directed programs with
//           scoreboard queues for memory reads, IR/AR loads, DR loads and
//           execute handoffs, plus timing and reset checks.
module tb_fetch_sequencer;

  logic       CLK, RSTN;
  logic       MEM_REQ, MEM_ACK;
  logic [5:0] MEM_ADDR;
  logic [8:0] MEM_RDATA;
  logic       LD_IR, LD_AR, LD_DR;
  logic [2:0] IR_DATA;
  logic [5:0] AR_DATA;
  logic [8:0] DR_DATA;
  logic       EXEC_VALID, EXEC_DONE, ZERO;
  logic [5:0] PC;
  logic       HALTED;

  fetch_sequencer dut (
    .CLK(CLK), .RSTN(RSTN),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .LD_IR(LD_IR), .IR_DATA(IR_DATA), .LD_AR(LD_AR), .AR_DATA(AR_DATA),
    .LD_DR(LD_DR), .DR_DATA(DR_DATA),
    .EXEC_VALID(EXEC_VALID), .EXEC_DONE(EXEC_DONE), .ZERO(ZERO),
    .PC(PC), .HALTED(HALTED)
  );

  localparam logic [8:0] W_HLT = 9'b111_000000;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int ack_delay  = 0;
  int exec_delay = 0;
  bit ack_noise  = 0;
  bit exec_noise = 0;

  logic [8:0] mem [64];

  logic [5:0] q_rd [$];
  logic [8:0] q_ir [$];
  logic [8:0] q_dr [$];
  logic [2:0] q_ex [$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value %0h", name, act);
  endtask

  // Memory responder: ACK after ack_delay wait cycles; optional junk ACK
  // while no request is outstanding.
  initial begin : mem_drv
    int cnt;
    cnt = 0;
    MEM_ACK = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (RSTN && MEM_REQ) begin
        if (cnt >= ack_delay) begin
          MEM_ACK = 1'b1;
          MEM_RDATA = mem[MEM_ADDR];
          cnt = 0;
        end else begin
          MEM_ACK = 1'b0;
          MEM_RDATA = '0;
          cnt++;
        end
      end else begin
        MEM_ACK = ack_noise;
        MEM_RDATA = ack_noise ? 9'h1FF : 9'h000;
        cnt = 0;
      end
    end
  end

  // Execute responder: DONE after exec_delay cycles of VALID.
  initial begin : exec_drv
    int cnt;
    cnt = 0;
    EXEC_DONE = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RSTN && EXEC_VALID) begin
        if (cnt >= exec_delay) begin
          EXEC_DONE = 1'b1;
          cnt = 0;
        end else begin
          EXEC_DONE = 1'b0;
          cnt++;
        end
      end else begin
        EXEC_DONE = exec_noise;
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  initial begin : monitor
    logic       p_req, p_ack, p_vld, p_done;
    logic [5:0] p_addr;
    p_req = 0; p_ack = 0; p_vld = 0; p_done = 0; p_addr = '0;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        p_req = 0; p_vld = 0;
        continue;
      end
      if (p_req && !p_ack && MEM_REQ) chk("addr_stable", MEM_ADDR, p_addr);
      if (MEM_REQ && MEM_ACK) begin
        if (q_rd.size() == 0) unexp("read", MEM_ADDR);
        else chk("read_addr", MEM_ADDR, q_rd.pop_front());
      end
      if (LD_IR || LD_AR) begin
        chk("ir_ar_pair", {LD_IR, LD_AR}, 2'b11);
        chk("dr_excl", LD_DR, 0);
        if (q_ir.size() == 0) unexp("ld_ir", {IR_DATA, AR_DATA});
        else chk("ir_ar_data", {IR_DATA, AR_DATA}, q_ir.pop_front());
      end
      if (LD_DR) begin
        if (q_dr.size() == 0) unexp("ld_dr", DR_DATA);
        else chk("dr_data", DR_DATA, q_dr.pop_front());
      end
      if (p_vld && !p_done) chk("exec_hold", EXEC_VALID, 1);
      if (EXEC_VALID && EXEC_DONE) begin
        if (q_ex.size() == 0) unexp("exec", IR_DATA);
        else chk("exec_op", IR_DATA, q_ex.pop_front());
      end
      p_req = MEM_REQ; p_ack = MEM_ACK; p_addr = MEM_ADDR;
      p_vld = EXEC_VALID; p_done = EXEC_DONE;
    end
  end

  task automatic hold_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    q_rd.delete(); q_ir.delete(); q_dr.delete(); q_ex.delete();
    for (int i = 0; i < 64; i++) mem[i] = W_HLT;
    repeat (2) @(negedge CLK);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic wait_req(input logic [5:0] a, input string name, output int t);
    t = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (MEM_REQ && MEM_ADDR == a) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) unexp(name, a);
  endtask

  task automatic run_to_halt(input string name);
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (HALTED) break;
    end
    chk(name, HALTED, 1);
  endtask

  task automatic end_checks(input string name);
    chk({name, "_rd_left"}, q_rd.size(), 0);
    chk({name, "_ir_left"}, q_ir.size(), 0);
    chk({name, "_dr_left"}, q_dr.size(), 0);
    chk({name, "_ex_left"}, q_ex.size(), 0);
  endtask

  initial begin : main
    int t0, t1, reqs, nhalt;
    RSTN = 1'b0;
    ZERO = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = W_HLT;
    repeat (2) @(negedge CLK);

    // Reset state
    chk("rst_req", MEM_REQ, 0);
    chk("rst_ld", {LD_IR, LD_AR, LD_DR}, 0);
    chk("rst_exec_valid", EXEC_VALID, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_pc", PC, 0);
    chk("rst_ir", IR_DATA, 0);
    chk("rst_ar", AR_DATA, 0);
    chk("rst_dr", DR_DATA, 0);

    // NOP at address 0, zero-wait ACK
    mem[0] = 9'b000_000101;
    q_rd.push_back(6'd0); q_rd.push_back(6'd1);
    q_ir.push_back(9'b000_000101); q_ir.push_back(W_HLT);
    release_reset();
    @(negedge CLK);
    chk("nop_req_first", MEM_REQ, 1);
    chk("nop_addr_first", MEM_ADDR, 0);
    @(negedge CLK);
    chk("nop_ld_ir", LD_IR, 1);
    chk("nop_pc", PC, 1);
    run_to_halt("nop_halt");
    end_checks("nop");

    // LDA with 3-cycle ACK delay: 11 cycles per instruction
    hold_reset();
    ack_delay = 3; exec_delay = 0;
    mem[0] = 9'b001_100000; mem[32] = 9'h1A5;
    q_rd.push_back(6'd0); q_rd.push_back(6'd32); q_rd.push_back(6'd1);
    q_ir.push_back(9'b001_100000); q_ir.push_back(W_HLT);
    q_dr.push_back(9'h1A5);
    q_ex.push_back(3'd1);
    release_reset();
    wait_req(6'd0, "lda_req0", t0);
    wait_req(6'd1, "lda_req1", t1);
    chk("lda_cycles", t1 - t0, 11);
    run_to_halt("lda_halt");
    chk("lda_dr_hold", DR_DATA, 9'h1A5);
    end_checks("lda");

    // STA with EXEC_DONE delayed 3 cycles: EXEC_VALID must hold
    hold_reset();
    ack_delay = 0; exec_delay = 3;
    mem[0] = 9'b011_000111;
    q_rd.push_back(6'd0); q_rd.push_back(6'd1);
    q_ir.push_back(9'b011_000111); q_ir.push_back(W_HLT);
    q_ex.push_back(3'd3);
    release_reset();
    wait_req(6'd0, "sta_req0", t0);
    wait_req(6'd1, "sta_req1", t1);
    chk("sta_cycles", t1 - t0, 6);
    run_to_halt("sta_halt");
    end_checks("sta");

    // JZ taken
    hold_reset();
    exec_delay = 0; ZERO = 1'b1;
    mem[0] = 9'b101_010000;
    q_rd.push_back(6'd0); q_rd.push_back(6'd16);
    q_ir.push_back(9'b101_010000); q_ir.push_back(W_HLT);
    release_reset();
    wait_req(6'd0, "jz1_req0", t0);
    wait_req(6'd16, "jz1_req16", t1);
    chk("jz1_cycles", t1 - t0, 2);
    run_to_halt("jz1_halt");
    end_checks("jz1");

    // JZ not taken
    hold_reset();
    ZERO = 1'b0;
    mem[0] = 9'b101_010000;
    q_rd.push_back(6'd0); q_rd.push_back(6'd1);
    q_ir.push_back(9'b101_010000); q_ir.push_back(W_HLT);
    release_reset();
    wait_req(6'd0, "jz0_req0", t0);
    wait_req(6'd1, "jz0_req1", t1);
    chk("jz0_cycles", t1 - t0, 2);
    run_to_halt("jz0_halt");
    end_checks("jz0");

    // JMP to 63 then NOP: PC wraps to 0
    hold_reset();
    mem[0] = 9'b100_111111; mem[63] = 9'b000_001010;
    q_rd.push_back(6'd0); q_rd.push_back(6'd63); q_rd.push_back(6'd0);
    q_ir.push_back(9'b100_111111); q_ir.push_back(9'b000_001010); q_ir.push_back(W_HLT);
    release_reset();
    wait_req(6'd63, "wrap_req63", t0);
    mem[0] = W_HLT;
    @(negedge CLK);
    chk("wrap_pc", PC, 0);
    wait_req(6'd0, "wrap_req0", t1);
    chk("wrap_cycles", t1 - t0, 2);
    run_to_halt("wrap_halt");
    end_checks("wrap");

    // ADD then HLT with junk ACK/DONE outside their handshakes
    hold_reset();
    ack_delay = 1; exec_delay = 1; ack_noise = 1; exec_noise = 1;
    mem[0] = 9'b010_000101; mem[5] = 9'h0F3;
    q_rd.push_back(6'd0); q_rd.push_back(6'd5); q_rd.push_back(6'd1);
    q_ir.push_back(9'b010_000101); q_ir.push_back(W_HLT);
    q_dr.push_back(9'h0F3);
    q_ex.push_back(3'd2);
    release_reset();
    t0 = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (LD_IR && IR_DATA == 3'd7) begin
        t0 = n;
        break;
      end
    end
    if (t0 < 0) unexp("hlt_decode_seen", 0);
    chk("hlt_decode_halted", HALTED, 0);
    @(negedge CLK);
    chk("hlt_halted_next", HALTED, 1);
    chk("hlt_req_next", MEM_REQ, 0);
    reqs = 0; nhalt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (MEM_REQ) reqs++;
      if (!HALTED || EXEC_VALID) nhalt++;
    end
    chk("hlt_req_count", reqs, 0);
    chk("hlt_stuck", nhalt, 0);
    chk("hlt_pc", PC, 2);
    chk("hlt_dr_hold", DR_DATA, 9'h0F3);
    chk("hlt_ir_ar_hold", {IR_DATA, AR_DATA}, W_HLT);
    end_checks("hlt");
    ack_noise = 0; exec_noise = 0;

    // Asynchronous reset in the middle of an operand read
    hold_reset();
    ack_delay = 3; exec_delay = 0;
    mem[0] = 9'b001_101000; mem[40] = 9'h155;
    q_rd.push_back(6'd0);
    q_ir.push_back(9'b001_101000);
    release_reset();
    wait_req(6'd40, "mid_req40", t0);
    #2;
    RSTN = 1'b0;
    #1;
    chk("mid_req_drop", MEM_REQ, 0);
    chk("mid_ld_drop", {LD_IR, LD_AR, LD_DR}, 0);
    chk("mid_exec_drop", EXEC_VALID, 0);
    chk("mid_pc", PC, 0);
    chk("mid_ar", AR_DATA, 0);
    end_checks("mid");
    mem[0] = W_HLT;
    q_rd.push_back(6'd0);
    q_ir.push_back(W_HLT);
    release_reset();
    wait_req(6'd0, "mid_restart", t1);
    run_to_halt("mid_halt");
    chk("mid_dr", DR_DATA, 0);
    end_checks("mid2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
